// File: rtl/division_arbiter.sv
// division_arbiter: shares one divider between NREQ requesters in round-robin
// order, answers trivial operands locally and guards the divider with a watchdog.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

module division_arbiter #(
  parameter int  NREQ    = 4,
  parameter int  TIMEOUT = 1024,
  localparam int W       = `DATAWIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   req_dividend,
  input  logic [NREQ*W-1:0]   req_divisor,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     done,
  output logic                err,
  output logic [W-1:0]        quotient,
  output logic [W-1:0]        remainder,
  output logic                busy,
  output logic                div_enable,
  output logic [W-1:0]        div_dividend,
  output logic [W-1:0]        div_divisor,
  input  logic                div_ready,
  input  logic [W-1:0]        div_quotient,
  input  logic [W-1:0]        div_remainder
);

  localparam int          PW       = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_reg;
  logic [PW-1:0]   ptr_reg;
  logic [15:0]     wd_reg;
  logic            timeout_reg;
  logic [NREQ-1:0] grant_reg;
  logic [NREQ-1:0] done_reg;
  logic            err_reg;
  logic [W-1:0]    quotient_reg;
  logic [W-1:0]    remainder_reg;
  logic            div_enable_reg;
  logic [W-1:0]    div_dividend_reg;
  logic [W-1:0]    div_divisor_reg;

  logic [W-1:0]    op_dividend [NREQ];
  logic [W-1:0]    op_divisor  [NREQ];

  logic            sel_valid;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   cand;
  logic [W-1:0]    sel_dividend;
  logic [W-1:0]    sel_divisor;
  logic [NREQ-1:0] sel_onehot;
  logic [PW-1:0]   ptr_after;
  logic [15:0]     wd_next;
  logic            wd_expired;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_dividend[gi] = req_dividend[gi*W +: W];
    assign op_divisor[gi]  = req_divisor[gi*W +: W];
  end

  // Scan from the farthest offset down so the nearest set bit at or after the pointer wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (int'(ptr_reg) + off >= NREQ) begin
        cand = PW'(int'(ptr_reg) + off - NREQ);
      end else begin
        cand = PW'(int'(ptr_reg) + off);
      end
      if (req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign sel_dividend = op_dividend[sel_idx];
  assign sel_divisor  = op_divisor[sel_idx];
  assign sel_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
  assign ptr_after    = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;

  // Watchdog saturates at the limit; expiry is judged on the incremented value.
  assign wd_next    = (wd_reg >= WD_LIMIT) ? WD_LIMIT : wd_reg + 16'd1;
  assign wd_expired = (wd_next >= WD_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= S_FLUSH;
      ptr_reg          <= '0;
      wd_reg           <= '0;
      timeout_reg      <= 1'b0;
      grant_reg        <= '0;
      done_reg         <= '0;
      err_reg          <= 1'b0;
      quotient_reg     <= '0;
      remainder_reg    <= '0;
      div_enable_reg   <= 1'b0;
      div_dividend_reg <= '0;
      div_divisor_reg  <= '0;
    end else begin
      done_reg       <= '0;
      div_enable_reg <= 1'b0;
      case (state_reg)
        S_FLUSH: begin
          if (div_ready || wd_expired) begin
            state_reg <= S_IDLE;
            wd_reg    <= '0;
          end else begin
            wd_reg <= wd_next;
          end
        end

        S_IDLE: begin
          if (sel_valid) begin
            grant_reg <= sel_onehot;
            ptr_reg   <= ptr_after;
            if (sel_divisor == '0) begin
              err_reg       <= 1'b1;
              quotient_reg  <= '1;
              remainder_reg <= sel_dividend;
              done_reg      <= sel_onehot;
              state_reg     <= S_RESP;
            end else if (sel_divisor == W'(1)) begin
              err_reg       <= 1'b0;
              quotient_reg  <= sel_dividend;
              remainder_reg <= '0;
              done_reg      <= sel_onehot;
              state_reg     <= S_RESP;
            end else if (sel_dividend < sel_divisor) begin
              err_reg       <= 1'b0;
              quotient_reg  <= '0;
              remainder_reg <= sel_dividend;
              done_reg      <= sel_onehot;
              state_reg     <= S_RESP;
            end else begin
              div_dividend_reg <= sel_dividend;
              div_divisor_reg  <= sel_divisor;
              div_enable_reg   <= 1'b1;
              state_reg        <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          wd_reg    <= '0;
          state_reg <= S_GUARD;
        end

        // The divider's ready from its previous result may still be high here.
        S_GUARD: begin
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          if (div_ready) begin
            err_reg       <= 1'b0;
            quotient_reg  <= div_quotient;
            remainder_reg <= div_remainder;
            done_reg      <= grant_reg;
            state_reg     <= S_RESP;
          end else if (wd_expired) begin
            wd_reg        <= wd_next;
            err_reg       <= 1'b1;
            quotient_reg  <= '1;
            remainder_reg <= '0;
            done_reg      <= grant_reg;
            timeout_reg   <= 1'b1;
            state_reg     <= S_RESP;
          end else begin
            wd_reg <= wd_next;
          end
        end

        S_RESP: begin
          grant_reg   <= '0;
          wd_reg      <= '0;
          timeout_reg <= 1'b0;
          state_reg   <= timeout_reg ? S_FLUSH : S_IDLE;
        end

        default: begin
          state_reg <= S_FLUSH;
        end
      endcase
    end
  end

  assign grant        = grant_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign quotient     = quotient_reg;
  assign remainder    = remainder_reg;
  assign busy         = (state_reg != S_IDLE);
  assign div_enable   = div_enable_reg;
  assign div_dividend = div_dividend_reg;
  assign div_divisor  = div_divisor_reg;

endmodule

// File: tb/tb_division_arbiter.sv
// Bench for division_arbiter: stub divider with programmable latency and a
// behavioural model (plain division, round-robin by list scan) for expectations.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

module tb_division_arbiter;
  localparam int NREQ = 4;
  localparam int TOUT = 16;
  localparam int W    = `DATAWIDTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] req_dividend = '0;
  logic [NREQ*W-1:0] req_divisor = '0;
  logic [NREQ-1:0]   grant, done;
  logic              err, busy, div_enable;
  logic [W-1:0]      quotient, remainder, div_dividend, div_divisor;
  logic              div_ready;
  logic [W-1:0]      div_quotient, div_remainder;

  division_arbiter #(.NREQ(NREQ), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .grant(grant), .done(done), .err(err),
    .quotient(quotient), .remainder(remainder), .busy(busy),
    .div_enable(div_enable), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  // Stub divider: ready drops when enable is sampled and rises stub_lat edges later.
  logic         stub_rdy = 1'b1;
  int           stub_cnt = 0;
  int           stub_lat = 1;
  logic         hang = 1'b0;
  logic [W-1:0] stub_q = '0, stub_r = '0;
  int           en_total = 0;

  always @(posedge clk) begin
    if (div_enable) begin
      en_total <= en_total + 1;
      stub_rdy <= 1'b0;
      stub_cnt <= stub_lat - 1;
      stub_q   <= div_dividend / div_divisor;
      stub_r   <= div_dividend % div_divisor;
    end else if (!stub_rdy && !hang) begin
      if (stub_cnt == 0) stub_rdy <= 1'b1;
      else stub_cnt <= stub_cnt - 1;
    end
  end

  assign div_ready     = stub_rdy;
  assign div_quotient  = stub_q;
  assign div_remainder = stub_r;

  int compared = 0;
  int mismatched = 0;
  int mptr = 0;
  logic [W-1:0] opa [NREQ];
  logic [W-1:0] opb [NREQ];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Arithmetic meaning of a request, independent of how the DUT gets there.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic e, output logic uses_div);
    e = 1'b0;
    uses_div = 1'b0;
    if (b == 0) begin
      q = '1; r = a; e = 1'b1;
    end else begin
      q = W'(a / b); r = W'(a % b);
      uses_div = (b != 1) && (a >= b);
    end
  endtask

  function automatic int next_winner(input logic [NREQ-1:0] pend, input int p);
    for (int off = 0; off < NREQ; off++) begin
      if (pend[(p + off) % NREQ]) return (p + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic wait_done(output int n, output logic got);
    n = 0;
    got = 1'b0;
    while (n < 200 && !got) begin
      @(posedge clk); #1;
      n++;
      if (done != 0) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'd1);
  endtask

  task automatic do_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int lat, input logic hung);
    logic [W-1:0] eq, er;
    logic ee, ud;
    int n, en0, exp_lat;
    logic got;
    model(a, b, eq, er, ee, ud);
    if (hung) begin
      eq = '1; er = '0; ee = 1'b1;
    end
    exp_lat = ud ? 3 + (hung ? TOUT : lat) : 1;
    stub_lat = lat;
    hang = hung;
    en0 = en_total;
    @(negedge clk);
    req_dividend[idx*W +: W] = a;
    req_divisor[idx*W +: W]  = b;
    req[idx] = 1'b1;
    wait_done(n, got);
    check("done_owner", 64'(done), 64'(1 << idx));
    check("grant_owner", 64'(grant), 64'(1 << idx));
    check("quotient", 64'(quotient), 64'(eq));
    check("remainder", 64'(remainder), 64'(er));
    check("err", 64'(err), 64'(ee));
    check("latency", 64'(n), 64'(exp_lat));
    req[idx] = 1'b0;
    mptr = (idx + 1) % NREQ;
    @(negedge clk);
    check("enable_pulses", 64'(en_total - en0), 64'(ud ? 1 : 0));
    $display("op req%0d %0d/%0d lat=%0d -> done=%b q=%0d r=%0d err=%0b cycles=%0d",
             idx, a, b, lat, done, quotient, remainder, err, n);
  endtask

  // Several requesters at once; hold keeps every req high for nops operations.
  task automatic rr_run(input logic [NREQ-1:0] mask, input int nops, input logic hold);
    logic [NREQ-1:0] pend;
    logic [W-1:0] eq, er;
    logic ee, ud, got;
    int n, w, ops;
    pend = mask;
    ops = 0;
    hang = 1'b0;
    stub_lat = $urandom_range(1, 5);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_dividend[i*W +: W] = opa[i];
      req_divisor[i*W +: W]  = opb[i];
    end
    req = mask;
    while (pend != 0 && ops < nops) begin
      w = next_winner(pend, mptr);
      model(opa[w], opb[w], eq, er, ee, ud);
      wait_done(n, got);
      if (!got) break;
      check("rr_done", 64'(done), 64'(1 << w));
      check("rr_grant", 64'(grant), 64'(1 << w));
      check("rr_quotient", 64'(quotient), 64'(eq));
      check("rr_remainder", 64'(remainder), 64'(er));
      check("rr_err", 64'(err), 64'(ee));
      $display("rr mask=%b winner=%0d done=%b q=%0d r=%0d err=%0b", mask, w, done,
               quotient, remainder, err);
      mptr = (w + 1) % NREQ;
      ops++;
      if (!hold) begin
        pend[w] = 1'b0;
        req[w] = 1'b0;
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic got;
    int seen;
    logic [W-1:0] a, b;

    // Reset with divider idle-ready
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_q", 64'(quotient), 64'd0);
    check("rst_r", 64'(remainder), 64'd0);
    check("rst_en", 64'(div_enable), 64'd0);
    check("rst_ops", 64'({div_dividend, div_divisor}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("flush_exit_busy", 64'(busy), 64'd0);
    $display("reset released, busy=%0b", busy);

    // Directed operations
    do_op(0, 100, 7, 5, 1'b0);
    do_op(2, 0, 5, 1, 1'b0);
    do_op(2, 9, 0, 1, 1'b0);
    do_op(2, 37, 1, 1, 1'b0);

    // Fairness under continuous contention
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = 200; opb[i] = 3;
    end
    rr_run(4'b1111, 8, 1'b1);

    // Randomized single requests
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 4))
        0: begin a = W'($urandom); b = 0; end
        1: begin a = W'($urandom); b = 1; end
        2: begin b = W'($urandom_range(2, 60000)); a = W'($urandom_range(0, int'(b) - 1)); end
        default: begin b = W'($urandom_range(2, 300)); a = W'($urandom_range(int'(b), 65535)); end
      endcase
      do_op($urandom_range(0, NREQ - 1), a, b, $urandom_range(1, 6), 1'b0);
    end

    // Randomized contention batches
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        opb[i] = W'($urandom_range(0, 40));
        opa[i] = W'($urandom_range(0, 5000));
      end
      rr_run(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 100, 1'b0);
    end

    // Watchdog: divider never answers, then FLUSH holds until ready returns
    do_op(1, 5000, 7, 1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("flush_hold_busy", 64'(busy), 64'd1);
    @(negedge clk);
    hang = 1'b0;
    n = 0;
    while (n < 3 && busy) begin
      @(posedge clk); #1;
      n++;
    end
    check("flush_release", 64'(busy), 64'd0);
    $display("timeout recovery, busy=%0b after %0d cycles", busy, n);

    // Reset while waiting on the divider
    stub_lat = 12;
    @(negedge clk);
    req_dividend[1*W +: W] = 1000;
    req_divisor[1*W +: W]  = 7;
    req[1] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    @(posedge clk); #1;
    check("midrst_busy", 64'(busy), 64'd1);
    check("midrst_grant", 64'(grant), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    n = 0;
    seen = 0;
    while (n < 40 && busy) begin
      @(posedge clk); #1;
      n++;
      if (done != 0) seen++;
    end
    check("midrst_idle", 64'(busy), 64'd0);
    check("midrst_no_done", 64'(seen), 64'd0);
    $display("mid-op reset recovered after %0d cycles, stray done=%0d", n, seen);
    do_op(1, 1000, 7, 3, 1'b0);
    do_op(3, 65535, 255, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/division_arbiter.md
# division_arbiter

Round-robin arbiter and sequencer that shares one `division` unit between `NREQ` requesters, such as the point-add, point-double and inversion controllers of the ECEG datapath. It accepts one request at a time. Trivial cases (divisor 0 or 1, dividend < divisor) are answered locally without using the divider. Other requests are issued to the divider with a safe enable/ready handshake, and the result is returned to the owning requester. A watchdog covers a hung divider, and a flush phase after reset lets the divider drain.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 1024: maximum cycles spent in WAIT, or in FLUSH, before the watchdog fires.
- Datapath width is `` `DATAWIDTH `` from `parameters.vh`, abbreviated W below.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req` in NREQ: per-requester request level.
- `req_dividend` in NREQ*W: flattened; requester i uses bits [i*W +: W].
- `req_divisor` in NREQ*W: flattened, same layout.
- `grant` out NREQ: one-hot owner of the current operation, 0 when none.
- `done` out NREQ: one-cycle pulse on the owner's bit when the result is valid.
- `err` out 1: valid with `done`; 1 = divide-by-zero or watchdog timeout.
- `quotient` out W: result, valid with `done` and held until the next `done`.
- `remainder` out W: same validity rules as `quotient`.
- `busy` out 1: high in every state except IDLE.
- `div_enable` out 1: to divider `enable`.
- `div_dividend` out W: to divider `dividend`.
- `div_divisor` out W: to divider `divisor`.
- `div_ready` in 1: from divider `ready`.
- `div_quotient` in W: from divider `quotient`.
- `div_remainder` in W: from divider `remainder`.

## Operation
- All outputs are registered or decoded from registered state.
- States: FLUSH, IDLE, ISSUE, GUARD, WAIT, RESP.
- Reset: state = FLUSH. `grant`, `done`, `err`, `quotient`, `remainder`, `div_enable`, `div_dividend`, `div_divisor` = 0. `busy` = 1. Round-robin pointer = 0. Watchdog = 0.
- FLUSH: wait for `div_ready` = 1 or for the watchdog to reach `TIMEOUT`, then go to IDLE. The divider has no reset and may be mid-operation.
- IDLE:
  - If any `req` bit is set, select the first set bit at or after the pointer, wrapping modulo NREQ.
  - Latch that requester's operands, set `grant`, set pointer = winner + 1 (mod NREQ).
  - Next state:
    - divisor == 0 → RESP with `err`=1, q = all ones, r = dividend.
    - divisor == 1 → RESP with q = dividend, r = 0.
    - dividend < divisor → RESP with q = 0, r = dividend.
    - otherwise → ISSUE.
- ISSUE: `div_enable` = 1 for exactly this cycle. Operands are driven on `div_dividend`/`div_divisor` and stay stable until RESP. Watchdog cleared. Next state GUARD.
- GUARD: one cycle in which `div_ready` is ignored. The divider's ready from the previous operation clears one edge after enable is sampled. Next state WAIT.
- WAIT:
  - On `div_ready` = 1: capture `div_quotient`/`div_remainder`, go to RESP.
  - Otherwise increment the watchdog. At `TIMEOUT`, go to RESP with `err`=1, q = all ones, r = 0, and set a flag so that RESP exits to FLUSH.
- RESP: `done[owner]` = 1 and `err` valid for one cycle. `grant` clears on exit. Exit to IDLE, or to FLUSH after a timeout.
- Requester rules:
  - Hold `req` and operands stable until its `done`.
  - Drop `req` in the cycle after `done`.
  - A `req` still high in IDLE is a new request.
  - A request that drops before its `done` is unsupported; the operation completes regardless.
- Simultaneous requests are resolved by the round-robin pointer only. No requester waits more than NREQ−1 operations.
- Changes to `req` while `busy` are ignored until IDLE.

## Timing
- Acceptance happens at the IDLE edge T.
- Bypass path: `done` is high in cycle T+1.
- Divider path: ISSUE at T+1, GUARD at T+2, WAIT from T+3. If `div_ready` is seen in the k-th WAIT cycle, `done` is high at T+3+k.
- Minimum gap between two `done` pulses: 2 cycles (RESP→IDLE→RESP).
- Reset asserted mid-operation: the next edge forces the reset values; no `done` is produced for the aborted request; the block re-enters FLUSH.
- Watchdog: a 16-bit counter, saturating at `TIMEOUT`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, stub `div_ready`=1 → all outputs at their reset values; FLUSH→IDLE one cycle after release; `busy`=0.
- Single request: req[0], 100 / 7, stub divider ready 5 cycles after enable → `div_enable` for exactly one cycle; `done`=0001, q=14, r=2, `err`=0.
- Bypass: req[2] 0/5 → `done`=0100, q=0, r=0 at T+1, `div_enable` never rises. 9/0 → q=FF..F, r=9, `err`=1. 37/1 → q=37, r=0.
- Fairness: all four `req` held continuously, 8 operations of 200/3 → grant order 0,1,2,3,0,1,2,3; every result q=66, r=2.
- Timeout: `TIMEOUT`=16, stub never asserts ready → `done` with `err`=1 at T+3+16, then FLUSH until `div_ready`=1.
- Reset mid-operation: assert `rst_n`=0 during WAIT → no `done` for the aborted request, FLUSH entered; the next request completes correctly.
